// File: rtl/cpu_ddr_responder.sv
// Toggle req/ack CPU memory responder with a one-line 64-bit read cache.
// Reads and byte-enabled write-through writes go to a 64-bit DDR stream port.
module cpu_ddr_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter bit          CACHE_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req_addr,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_be,
    input  logic        req_rw,
    input  logic        req,
    output logic        ack,
    output logic [15:0] q,
    input  logic        flush,
    output logic [31:0] ddr_addr,
    output logic [63:0] ddr_wdata,
    input  logic [63:0] ddr_rdata,
    output logic        ddr_read,
    output logic        ddr_write,
    output logic [7:0]  ddr_burstcnt,
    output logic [7:0]  ddr_byteenable,
    input  logic        ddr_busy,
    input  logic        ddr_read_complete
);

    typedef enum logic [1:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD} state_t;

    state_t        state, state_n;
    logic          valid;
    logic [31:3]   tag;
    logic [63:0]   line;
    logic [31:1]   eff_p0;
    logic [31:1]   eff;
    logic [1:0]    lane;
    logic          pending;
    logic          hit;
    logic          fill_en;
    logic          merge_en;
    logic [7:0]    wr_be;

    function automatic logic [15:0] lane_sel(input logic [63:0] d, input logic [1:0] w);
        return d[{w, 4'b0000} +: 16];
    endfunction

    function automatic logic [63:0] merge_bytes(input logic [63:0] d, input logic [63:0] wd,
                                                input logic [7:0] be);
        logic [63:0] r;
        r = d;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    assign ddr_burstcnt = 8'd1;

    // Bit 0 of the sum is never used, so only its carry into bit 1 is kept.
    always_comb begin
        eff      = BASE_ADDR[31:1] + req_addr[31:1] + {30'b0, BASE_ADDR[0] & req_addr[0]};
        lane     = eff[2:1];
        pending  = (req != ack);
        hit      = CACHE_EN && valid && (tag == eff[31:3]);
        wr_be    = {6'b0, req_be} << {lane, 1'b0};
        fill_en  = (state == RD_WAIT) && ddr_read_complete;
        merge_en = (state == IDLE) && pending && !req_rw && hit;
        state_n  = state;
        case (state)
            IDLE: begin
                if (pending) begin
                    if (!req_rw)  state_n = WR_CMD;
                    else if (!hit) state_n = RD_CMD;
                end
            end
            RD_CMD:  if (!ddr_busy)         state_n = RD_WAIT;
            RD_WAIT: if (ddr_read_complete) state_n = IDLE;
            WR_CMD:  if (!ddr_busy)         state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Stage p0: control, handshake and DDR command registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ack            <= 1'b0;
            q              <= 16'h0;
            ddr_read       <= 1'b0;
            ddr_write      <= 1'b0;
            ddr_addr       <= 32'h0;
            ddr_wdata      <= 64'h0;
            ddr_byteenable <= 8'h0;
            valid          <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (pending) begin
                        if (req_rw && hit) begin
                            q   <= lane_sel(line, lane);
                            ack <= ~ack;
                        end else if (req_rw) begin
                            ddr_addr       <= {eff[31:3], 3'b000};
                            ddr_byteenable <= 8'hFF;
                            ddr_read       <= 1'b1;
                        end else begin
                            ddr_addr       <= {eff[31:3], 3'b000};
                            ddr_wdata      <= {4{req_data}};
                            ddr_byteenable <= wr_be;
                            ddr_write      <= 1'b1;
                        end
                    end
                end
                RD_CMD: if (!ddr_busy) ddr_read <= 1'b0;
                RD_WAIT: begin
                    if (ddr_read_complete) begin
                        valid <= CACHE_EN;
                        q     <= lane_sel(ddr_rdata, eff_p0[2:1]);
                        ack   <= ~ack;
                    end
                end
                WR_CMD: begin
                    if (!ddr_busy) begin
                        ddr_write <= 1'b0;
                        ack       <= ~ack;
                    end
                end
                default: ;
            endcase
            // A flush overrides any fill or merge in the same cycle.
            if (flush) valid <= 1'b0;
        end
    end

    // Stage p0 data: captured request address and cache line contents.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && pending) eff_p0 <= eff;
        if (fill_en) begin
            line <= ddr_rdata;
            tag  <= eff_p0[31:3];
        end else if (merge_en) begin
            line <= merge_bytes(line, {4{req_data}}, wr_be);
        end
    end

endmodule

// File: tb/tb_cpu_ddr_responder.sv
// Scoreboard bench for cpu_ddr_responder with a behavioural DDR memory.
module tb_cpu_ddr_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] req_addr;
    logic [15:0] req_data;
    logic [1:0]  req_be;
    logic        req_rw;
    logic        req;
    logic        ack;
    logic [15:0] q;
    logic        flush;
    logic [31:0] ddr_addr;
    logic [63:0] ddr_wdata;
    logic [63:0] ddr_rdata;
    logic        ddr_read;
    logic        ddr_write;
    logic [7:0]  ddr_burstcnt;
    logic [7:0]  ddr_byteenable;
    logic        ddr_busy;
    logic        ddr_read_complete;

    logic [31:0] w_req_addr;
    logic [15:0] w_req_data;
    logic [1:0]  w_req_be;
    logic        w_req_rw;
    logic        w_req;
    logic        w_ack;
    logic [15:0] w_q;
    logic        w_flush;
    logic [31:0] w_ddr_addr;
    logic [63:0] w_ddr_wdata;
    logic [63:0] w_ddr_rdata;
    logic        w_ddr_read;
    logic        w_ddr_write;
    logic [7:0]  w_ddr_burstcnt;
    logic [7:0]  w_ddr_byteenable;
    logic        w_ddr_busy;
    logic        w_ddr_read_complete;

    cpu_ddr_responder #(.BASE_ADDR(32'h0000_0000), .CACHE_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .req_addr(req_addr), .req_data(req_data),
        .req_be(req_be), .req_rw(req_rw), .req(req), .ack(ack), .q(q), .flush(flush),
        .ddr_addr(ddr_addr), .ddr_wdata(ddr_wdata), .ddr_rdata(ddr_rdata),
        .ddr_read(ddr_read), .ddr_write(ddr_write), .ddr_burstcnt(ddr_burstcnt),
        .ddr_byteenable(ddr_byteenable), .ddr_busy(ddr_busy),
        .ddr_read_complete(ddr_read_complete)
    );

    cpu_ddr_responder #(.BASE_ADDR(32'hFFFF_FFF8), .CACHE_EN(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .req_addr(w_req_addr), .req_data(w_req_data),
        .req_be(w_req_be), .req_rw(w_req_rw), .req(w_req), .ack(w_ack), .q(w_q),
        .flush(w_flush), .ddr_addr(w_ddr_addr), .ddr_wdata(w_ddr_wdata),
        .ddr_rdata(w_ddr_rdata), .ddr_read(w_ddr_read), .ddr_write(w_ddr_write),
        .ddr_burstcnt(w_ddr_burstcnt), .ddr_byteenable(w_ddr_byteenable),
        .ddr_busy(w_ddr_busy), .ddr_read_complete(w_ddr_read_complete)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    logic [63:0] ddr_mem [logic [31:0]];
    logic [63:0] exp_mem [logic [31:0]];
    logic [15:0] sb_q [$];
    logic [15:0] exp_held = 16'h0;

    function automatic logic [63:0] ddr_line(input logic [31:0] a);
        return ddr_mem.exists(a) ? ddr_mem[a] : 64'h0;
    endfunction

    function automatic logic [63:0] exp_line(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : 64'h0;
    endfunction

    function automatic logic [15:0] exp_word(input logic [31:0] a);
        logic [63:0] l;
        l = exp_line({a[31:3], 3'b000});
        return l[16*a[2:1] +: 16];
    endfunction

    task automatic exp_write(input logic [31:0] a, input logic [15:0] d, input logic [1:0] be);
        logic [63:0] l;
        l = exp_line({a[31:3], 3'b000});
        for (int b = 0; b < 2; b++) begin
            if (be[b]) l[16*a[2:1] + 8*b +: 8] = d[8*b +: 8];
        end
        exp_mem[{a[31:3], 3'b000}] = l;
    endtask

    // DDR model controls and observations
    int          busy_cfg = 0;
    int          rd_lat = 1;
    bit          flush_cfg = 1'b0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          rd_hi = 0;
    bit          both_hi = 1'b0;
    bit          addr_unstable = 1'b0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [63:0] last_wr_data = 64'h0;
    logic [7:0]  last_wr_be = 8'h0;

    initial begin : ddr_model
        int          phase;
        int          busy_left;
        int          lat_left;
        bit          in_cmd;
        bit          prev_rd;
        logic [31:0] cur_addr;
        logic [31:0] prev_addr;
        logic [63:0] l;
        phase = 0; busy_left = 0; lat_left = 0; in_cmd = 0; prev_rd = 0;
        cur_addr = 0; prev_addr = 0;
        ddr_busy = 1'b0; ddr_read_complete = 1'b0; ddr_rdata = 64'h0; flush = 1'b0;
        forever begin
            @(negedge clk);
            ddr_read_complete = 1'b0;
            flush = 1'b0;
            if (ddr_read && ddr_write) both_hi = 1'b1;
            if (ddr_read) begin
                rd_hi++;
                if (prev_rd && ddr_addr != prev_addr) addr_unstable = 1'b1;
            end
            prev_rd = ddr_read;
            prev_addr = ddr_addr;
            if (reset) begin
                phase = 0; in_cmd = 0; ddr_busy = 1'b0;
            end else if (phase == 1) begin
                ddr_busy = 1'b0;
                lat_left--;
                if (lat_left <= 0) begin
                    ddr_read_complete = 1'b1;
                    ddr_rdata = ddr_line(cur_addr);
                    flush = flush_cfg;
                    flush_cfg = 1'b0;
                    phase = 0;
                end
            end else if (ddr_read || ddr_write) begin
                if (!in_cmd) begin
                    in_cmd = 1; busy_left = busy_cfg; busy_cfg = 0;
                end
                if (busy_left > 0) begin
                    ddr_busy = 1'b1;
                    busy_left--;
                end else begin
                    ddr_busy = 1'b0;
                    in_cmd = 0;
                    if (ddr_read) begin
                        n_rd++; cur_addr = ddr_addr; lat_left = rd_lat; phase = 1;
                    end else begin
                        n_wr++;
                        last_wr_addr = ddr_addr; last_wr_data = ddr_wdata; last_wr_be = ddr_byteenable;
                        l = ddr_line(ddr_addr);
                        for (int i = 0; i < 8; i++) begin
                            if (ddr_byteenable[i]) l[8*i +: 8] = ddr_wdata[8*i +: 8];
                        end
                        ddr_mem[ddr_addr] = l;
                    end
                end
            end else begin
                ddr_busy = 1'b0;
            end
        end
    end

    // Every ack toggle retires the oldest expected q.
    initial begin : sb_monitor
        logic        ack_prev;
        logic [15:0] e;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ack_prev = 1'b0;
            end else if (ack != ack_prev) begin
                ack_prev = ack;
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_ack", 64'(ack), 64'(~ack));
                end else begin
                    e = sb_q.pop_front();
                    check_eq("sb_q", 64'(q), 64'(e));
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input bit rw, input logic [15:0] d,
                          input logic [1:0] be, output int lat);
        req_addr = a; req_rw = rw; req_data = d; req_be = be;
        if (rw) exp_held = exp_word(a);
        else exp_write(a, d, be);
        sb_q.push_back(exp_held);
        req = ~req;
        lat = 0;
        while (ack != req && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (ack != req) check_eq("ack_timeout", 64'(ack), 64'(req));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ack"}, 64'(ack), 64'(0));
        check_eq({tag, "_q"}, 64'(q), 64'(0));
        check_eq({tag, "_rd"}, 64'(ddr_read), 64'(0));
        check_eq({tag, "_wr"}, 64'(ddr_write), 64'(0));
        check_eq({tag, "_addr"}, 64'(ddr_addr), 64'(0));
        check_eq({tag, "_wdata"}, ddr_wdata, 64'(0));
        check_eq({tag, "_be"}, 64'(ddr_byteenable), 64'(0));
        check_eq({tag, "_burst"}, 64'(ddr_burstcnt), 64'(1));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        int n0;
        int w0;
        int k;
        reset = 1'b1;
        req = 1'b0; req_addr = 0; req_data = 0; req_be = 0; req_rw = 1'b1;
        w_req = 1'b0; w_req_addr = 0; w_req_data = 0; w_req_be = 0; w_req_rw = 1'b1;
        w_flush = 1'b0; w_ddr_rdata = 64'h0; w_ddr_busy = 1'b0; w_ddr_read_complete = 1'b0;
        ddr_mem[32'h100] = 64'h4444_3333_2222_1111; exp_mem[32'h100] = 64'h4444_3333_2222_1111;
        ddr_mem[32'h200] = 64'hDEAD_BEEF_CAFE_F00D; exp_mem[32'h200] = 64'hDEAD_BEEF_CAFE_F00D;
        ddr_mem[32'h400] = 64'h8888_7777_6666_5555; exp_mem[32'h400] = 64'h8888_7777_6666_5555;
        ddr_mem[32'h500] = 64'h0102_0304_0506_0708; exp_mem[32'h500] = 64'h0102_0304_0506_0708;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);

        // Address wrap on the second instance
        w_req_addr = 32'h10; w_req = 1'b1;
        k = 0;
        while (!w_ddr_read && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_eq("wrap_addr", 64'(w_ddr_addr), 64'h8);
        check_eq("wrap_be", 64'(w_ddr_byteenable), 64'hFF);
        check_eq("wrap_burst", 64'(w_ddr_burstcnt), 64'h1);
        check_eq("wrap_nowr", 64'(w_ddr_write), 64'h0);
        @(negedge clk);
        w_ddr_rdata = 64'h1111_2222_3333_BEEF;
        w_ddr_read_complete = 1'b1;
        @(negedge clk);
        w_ddr_read_complete = 1'b0;
        check_eq("wrap_ack", 64'(w_ack), 64'h1);
        check_eq("wrap_q", 64'(w_q), 64'hBEEF);
        check_eq("wrap_wdata", w_ddr_wdata, 64'h0);

        // Read miss then read hit
        n0 = n_rd;
        do_req(32'h100, 1'b1, 16'h0, 2'b00, lat);
        check_eq("miss_nrd", 64'(n_rd - n0), 64'd1);
        check_eq("miss_lat", 64'(lat), 64'd3);
        check_eq("miss_q", 64'(q), 64'h1111);
        n0 = n_rd; rd_hi = 0;
        do_req(32'h104, 1'b1, 16'h0, 2'b00, lat);
        check_eq("hit_nrd", 64'(n_rd - n0), 64'd0);
        check_eq("hit_rdhi", 64'(rd_hi), 64'd0);
        check_eq("hit_lat", 64'(lat), 64'd1);

        // Write hit merge, then read back from the cache
        do_req(32'h102, 1'b0, 16'hABCD, 2'b10, lat);
        check_eq("wr_be", 64'(last_wr_be), 64'h08);
        check_eq("wr_data", last_wr_data, 64'hABCD_ABCD_ABCD_ABCD);
        check_eq("wr_addr", 64'(last_wr_addr), 64'h100);
        check_eq("wr_lat", 64'(lat), 64'd2);
        n0 = n_rd;
        do_req(32'h102, 1'b1, 16'h0, 2'b00, lat);
        check_eq("merge_q", 64'(q), 64'hAB22);
        check_eq("merge_nrd", 64'(n_rd - n0), 64'd0);

        // Write miss and an all-disabled write
        do_req(32'h306, 1'b0, 16'h5A5A, 2'b01, lat);
        check_eq("wrmiss_be", 64'(last_wr_be), 64'h40);
        check_eq("wrmiss_addr", 64'(last_wr_addr), 64'h300);
        w0 = n_wr;
        do_req(32'h100, 1'b0, 16'h7777, 2'b00, lat);
        check_eq("be0_be", 64'(last_wr_be), 64'h00);
        check_eq("be0_nwr", 64'(n_wr - w0), 64'd1);
        n0 = n_rd;
        do_req(32'h104, 1'b1, 16'h0, 2'b00, lat);
        check_eq("after_wr_nrd", 64'(n_rd - n0), 64'd0);

        // Busy backpressure on a read miss
        busy_cfg = 5; rd_hi = 0; addr_unstable = 1'b0; n0 = n_rd;
        do_req(32'h402, 1'b1, 16'h0, 2'b00, lat);
        check_eq("busy_rdhi", 64'(rd_hi), 64'd6);
        check_eq("busy_addr_stable", 64'(addr_unstable), 64'd0);
        check_eq("busy_lat", 64'(lat), 64'd8);
        check_eq("busy_nrd", 64'(n_rd - n0), 64'd1);

        // Flush coincident with the fill
        flush_cfg = 1'b1;
        do_req(32'h206, 1'b1, 16'h0, 2'b00, lat);
        n0 = n_rd;
        do_req(32'h206, 1'b1, 16'h0, 2'b00, lat);
        check_eq("flush_refetch", 64'(n_rd - n0), 64'd1);

        // Reset while waiting for a fill with req high
        if (req) do_req(32'h206, 1'b1, 16'h0, 2'b00, lat);
        rd_lat = 10;
        req_addr = 32'h504; req_rw = 1'b1;
        exp_held = exp_word(32'h504);
        sb_q.push_back(exp_held);
        n0 = n_rd;
        req = 1'b1;
        k = 0;
        while (n_rd == n0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rd_lat = 1;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        k = 0;
        while (ack != req && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("midrst_ack", 64'(ack), 64'h1);
        check_eq("midrst_nrd", 64'(n_rd - n0), 64'd2);
        check_eq("midrst_q", 64'(q), 64'h0304);

        repeat (3) @(negedge clk);
        check_eq("both_cmds_high", 64'(both_hi), 64'd0);
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
